// File: rtl/atm_keypad_entry.sv
// Keypad front end for the ATM controller: debounces raw key presses and produces either a single
// key code or an accumulated decimal amount. Optional idle timeout: define ATM_KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 4,
    parameter int AMOUNT_W        = 11,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_down,
    input  logic [3:0]          key_raw,
    input  logic                mode_amount,
    input  logic                ack,
    output logic [3:0]          code_out,
    output logic                code_valid,
    output logic [AMOUNT_W-1:0] amount_out,
    output logic                amount_valid,
    output logic [2:0]          digit_count,
`ifdef ATM_KEYPAD_TIMEOUT_EN
    output logic                overflow,
    output logic                entry_timeout
`else
    output logic                overflow
`endif
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PROD_W = AMOUNT_W + 4;
    localparam logic [31:0]       DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [PROD_W-1:0] AMOUNT_MAX = PROD_W'((64'd1 << AMOUNT_W) - 64'd1);
    localparam logic [2:0]        MAX_DC     = 3'(MAX_DIGITS);

    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || MAX_DIGITS < 1 || MAX_DIGITS > 7) begin : g_bad_param
        $error("atm_keypad_entry: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } db_state_t;

    db_state_t           r_db_state;
    logic [DB_W-1:0]     r_db_cnt;
    logic [3:0]          r_key_l;
    logic                r_press;

    logic [3:0]          r_code_out;
    logic                r_code_valid;
    logic [AMOUNT_W-1:0] r_amount_out;
    logic                r_amount_valid;
    logic [AMOUNT_W-1:0] r_acc;
    logic [2:0]          r_digit_count;
    logic                r_overflow;
    logic                r_mode_d;

    logic                w_db_done;
    logic [PROD_W-1:0]   w_prod;
    logic                w_is_digit;
    logic                w_room;
    logic                w_mode_chg;
    logic                w_code_press;
    logic                w_amt_press;
    logic                w_timeout;

    // The sampling cycle in IDLE counts as the first stable cycle of a press or release.
    assign w_db_done = (32'(r_db_cnt) + 32'd1) >= DB_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_state <= S_IDLE;
            r_db_cnt   <= '0;
            r_key_l    <= '0;
            r_press    <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_db_state)
                S_IDLE: begin
                    if (key_down) begin
                        r_db_state <= S_PRESS_WAIT;
                        r_key_l    <= key_raw;
                        r_db_cnt   <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!key_down || key_raw != r_key_l) begin
                        r_db_state <= S_IDLE;
                    end else if (w_db_done) begin
                        r_db_state <= S_HELD;
                        r_press    <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!key_down) begin
                        r_db_state <= S_RELEASE_WAIT;
                        r_db_cnt   <= '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (key_down) begin
                        r_db_state <= S_HELD;
                    end else if (w_db_done) begin
                        r_db_state <= S_IDLE;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: r_db_state <= S_IDLE;
            endcase
        end
    end

    // Wide intermediate so the range check sees the true value instead of a wrapped one.
    assign w_prod       = ({4'b0000, r_acc} * PROD_W'(10)) + PROD_W'(r_key_l);
    assign w_is_digit   = (r_key_l <= 4'd9);
    assign w_room       = (r_digit_count < MAX_DC);
    assign w_mode_chg   = (mode_amount != r_mode_d);
    assign w_code_press = r_press && !mode_amount;
    assign w_amt_press  = r_press && mode_amount;

`ifdef ATM_KEYPAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_idle_cnt;
    logic            r_timeout;

    assign w_timeout     = (r_digit_count != 3'd0) && !r_press && (r_idle_cnt == TO_LAST);
    assign entry_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (r_press || r_digit_count == 3'd0 || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code_out     <= '0;
            r_code_valid   <= 1'b0;
            r_amount_out   <= '0;
            r_amount_valid <= 1'b0;
            r_acc          <= '0;
            r_digit_count  <= '0;
            r_overflow     <= 1'b0;
            r_mode_d       <= 1'b0;
        end else begin
            r_mode_d <= mode_amount;

            if (w_code_press && (!r_code_valid || ack)) begin
                r_code_out   <= r_key_l;
                r_code_valid <= 1'b1;
            end else if (ack) begin
                r_code_valid <= 1'b0;
            end

            if (ack && r_amount_valid) begin
                r_amount_valid <= 1'b0;
                r_amount_out   <= '0;
            end

            // A mode switch abandons any partial entry; committed values wait for their ack.
            if (w_mode_chg || w_timeout) begin
                r_acc         <= '0;
                r_digit_count <= '0;
                r_overflow    <= 1'b0;
            end else if (w_amt_press) begin
                if (w_is_digit) begin
                    if (w_room && (w_prod <= AMOUNT_MAX)) begin
                        r_acc         <= w_prod[AMOUNT_W-1:0];
                        r_digit_count <= r_digit_count + 3'd1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else if (r_key_l == 4'hA) begin
                    r_acc         <= '0;
                    r_digit_count <= '0;
                    r_overflow    <= 1'b0;
                end else if (r_key_l == 4'hB) begin
                    if (r_acc != '0 && !r_amount_valid) begin
                        r_amount_out   <= r_acc;
                        r_amount_valid <= 1'b1;
                        r_acc          <= '0;
                        r_digit_count  <= '0;
                        r_overflow     <= 1'b0;
                    end
                end
            end
        end
    end

    assign code_out     = r_code_out;
    assign code_valid   = r_code_valid;
    assign amount_out   = r_amount_out;
    assign amount_valid = r_amount_valid;
    assign digit_count  = r_digit_count;
    assign overflow     = r_overflow;

endmodule
